// File: rtl/ram_2p_clr.sv
// Simple dual-port synchronous RAM with a registered read port and a
// sequential clear engine. The clear engine sweeps the whole array to
// CLEAR_VAL after reset or on request. While the sweep runs, busy is high
// and the write and read ports are ignored.
module ram_2p_clr #(
  parameter int unsigned            DATA_WIDTH = 8,
  parameter int unsigned            ADDR_WIDTH = 4,
  parameter int unsigned            RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0]  CLEAR_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rd_valid
);

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam bit          RDW_WRITE = (RDW_MODE != 0);

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rd_valid_q, rd_valid_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // Next-state logic. The sweep and the user write share one array write
  // port. The sweep ends when the pointer reaches all-ones, so the pointer
  // never addresses past the last word.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = waddr;
    mem_wdata  = wdata;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = CLEAR_VAL;
        ptr_d     = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == '1) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end
      end
      S_IDLE: begin
        if (clr) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end else begin
          mem_we = we;
          if (re) begin
            rd_valid_d = 1'b1;
            if (RDW_WRITE && we && (waddr == raddr)) begin
              rdata_d = wdata;
            end else begin
              rdata_d = mem_q[raddr];
            end
          end
        end
      end
      default: begin
        state_d = S_CLEAR;
        ptr_d   = '0;
      end
    endcase
    busy_d = (state_d == S_CLEAR);
  end

  // Control and read-output registers, with asynchronous reset into the sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      ptr_q      <= '0;
      busy_q     <= 1'b1;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Array write port. The array has no reset; the clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign busy     = busy_q;
  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q;

endmodule
